venus_dma_csr: RTL and testbench

Responder side of the DMA control-register interface. Accepts `csr_req_t` write/read requests from the SoC bus adapter and holds the descriptor, configuration, status and error registers. Issues a one-cycle start to the DMA FSM/streamer, tracks active/done/error from it, and returns the full 64-byte register window as `csr_resp_t`.

---
 rtl/venus_dma_csr_pkg.sv | 57 +++++
 rtl/venus_dma_csr.sv | 143 ++++++++++++++
 tb/tb_venus_dma_csr.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/venus_dma_csr_pkg.sv
// Shared types and register map for the Venus DMA control-register window.
`ifndef VENUSDMA_CTRLREG_OFFSET
`define VENUSDMA_CTRLREG_OFFSET 32'h1ffe_0000
`endif

package venus_dma_csr_pkg;

  localparam int unsigned CSR_CFG_OFF       = 'h00;
  localparam int unsigned CSR_SRC_OFF       = 'h08;
  localparam int unsigned CSR_DST_OFF       = 'h10;
  localparam int unsigned CSR_LEN_OFF       = 'h18;
  localparam int unsigned CSR_STAT_OFF      = 'h20;
  localparam int unsigned CSR_ERRORADDR_OFF = 'h28;
  localparam int unsigned CSR_ERRORSRC_OFF  = 'h30;

  localparam int unsigned CFG_GO_BIT      = 0;
  localparam int unsigned CFG_IRQEN_BIT   = 1;
  localparam int unsigned STAT_ACTIVE_BIT = 0;
  localparam int unsigned STAT_DONE_BIT   = 1;
  localparam int unsigned STAT_ERR_BIT    = 2;

  typedef struct packed {
    logic        csr_wr_en;
    logic [31:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_rd_en;
  } csr_req_t;

  typedef struct packed {
    logic [511:0] csr_rdata;
  } csr_resp_t;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] num_bytes;
  } s_dma_desc_t;

  typedef enum logic [1:0] {
    DMA_AXI_RD_ERR = 2'd0,
    DMA_AXI_WR_ERR = 2'd1,
    DMA_DESC_ERR   = 2'd2,
    DMA_OTHER_ERR  = 2'd3
  } err_src_t;

  typedef struct packed {
    logic [31:0] addr;
    err_src_t    src;
    logic        valid;
  } s_dma_error_t;

  typedef enum logic {
    DMA_ST_IDLE = 1'b0,
    DMA_ST_RUN  = 1'b1
  } dma_sm_t;

endpackage

// File: rtl/venus_dma_csr.sv
// DMA CSR responder: register file, address decode, status FSM and read window.
module venus_dma_csr
  import venus_dma_csr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = `VENUSDMA_CTRLREG_OFFSET
) (
  input  logic         clk,
  input  logic         rst,
  input  csr_req_t     csr_req_i,
  output csr_resp_t    csr_resp_o,
  output logic         csr_rvalid_o,
  output s_dma_desc_t  desc_o,
  output logic         start_o,
  input  logic         done_i,
  input  s_dma_error_t error_i,
  output logic         irq_o
);

  dma_sm_t      state_q, state_d;
  logic         irqen_q, irqen_d;
  logic [31:0]  src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic         done_q, done_d, err_q, err_d;
  logic [31:0]  erraddr_q, erraddr_d;
  err_src_t     errsrc_q, errsrc_d;
  logic         start_q, start_d;
  logic [511:0] rdata_q, rdata_d;
  logic         rvalid_q;

  logic         wr_hit, active;
  logic [5:0]   woff;
  logic [31:0]  wdata;
  logic         sel_cfg, sel_src, sel_dst, sel_len, sel_stat;
  logic         go_req, w1c_done, w1c_err, done_set;
  logic [511:0] window;

  assign active = (state_q == DMA_ST_RUN);
  assign wr_hit = csr_req_i.csr_wr_en && (csr_req_i.csr_waddr[31:6] == BASE_ADDR[31:6]);
  assign woff   = csr_req_i.csr_waddr[5:0];
  assign wdata  = csr_req_i.csr_wdata;

  assign sel_cfg  = wr_hit && (woff == 6'(CSR_CFG_OFF));
  assign sel_src  = wr_hit && (woff == 6'(CSR_SRC_OFF));
  assign sel_dst  = wr_hit && (woff == 6'(CSR_DST_OFF));
  assign sel_len  = wr_hit && (woff == 6'(CSR_LEN_OFF));
  assign sel_stat = wr_hit && (woff == 6'(CSR_STAT_OFF));

  assign go_req   = sel_cfg  && wdata[CFG_GO_BIT];
  assign w1c_done = sel_stat && wdata[STAT_DONE_BIT];
  assign w1c_err  = sel_stat && wdata[STAT_ERR_BIT];

  always_comb begin
    window = '0;
    window[8*CSR_CFG_OFF       +: 32] = {30'b0, irqen_q, 1'b0};
    window[8*CSR_SRC_OFF       +: 32] = src_q;
    window[8*CSR_DST_OFF       +: 32] = dst_q;
    window[8*CSR_LEN_OFF       +: 32] = len_q;
    window[8*CSR_STAT_OFF      +: 32] = {29'b0, err_q, done_q, active};
    window[8*CSR_ERRORADDR_OFF +: 32] = erraddr_q;
    window[8*CSR_ERRORSRC_OFF  +: 32] = {30'b0, errsrc_q};
  end

  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    done_set = 1'b0;
    case (state_q)
      DMA_ST_IDLE: begin
        if (go_req) begin
          if (len_q != '0) begin
            state_d = DMA_ST_RUN;
            start_d = 1'b1;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      DMA_ST_RUN: begin
        if (done_i || error_i.valid) state_d = DMA_ST_IDLE;
        if (done_i) done_set = 1'b1;
      end
      default: state_d = DMA_ST_IDLE;
    endcase
  end

  always_comb begin
    irqen_d = sel_cfg ? wdata[CFG_IRQEN_BIT] : irqen_q;
    src_d   = (sel_src && !active) ? wdata : src_q;
    dst_d   = (sel_dst && !active) ? wdata : dst_q;
    len_d   = (sel_len && !active) ? wdata : len_q;
    // Hardware set wins over W1C; a new error arriving with the W1C is the first of the next episode.
    done_d    = (done_q & ~w1c_done) | done_set;
    err_d     = (err_q & ~w1c_err) | error_i.valid;
    erraddr_d = erraddr_q;
    errsrc_d  = errsrc_q;
    if (error_i.valid && (!err_q || w1c_err)) begin
      erraddr_d = error_i.addr;
      errsrc_d  = error_i.src;
    end else if (w1c_err) begin
      erraddr_d = '0;
      errsrc_d  = DMA_AXI_RD_ERR;
    end
    rdata_d = csr_req_i.csr_rd_en ? window : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DMA_ST_IDLE;
      irqen_q   <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      erraddr_q <= '0;
      errsrc_q  <= DMA_AXI_RD_ERR;
      start_q   <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      irqen_q   <= irqen_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      done_q    <= done_d;
      err_q     <= err_d;
      erraddr_q <= erraddr_d;
      errsrc_q  <= errsrc_d;
      start_q   <= start_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= csr_req_i.csr_rd_en;
    end
  end

  assign csr_resp_o.csr_rdata = rdata_q;
  assign csr_rvalid_o         = rvalid_q;
  assign start_o              = start_q;
  assign desc_o.src           = src_q;
  assign desc_o.dst           = dst_q;
  assign desc_o.num_bytes     = len_q;
  assign irq_o                = irqen_q & (done_q | err_q);

endmodule

// File: tb/tb_venus_dma_csr.sv
// Scoreboard bench for venus_dma_csr: reads push expectations, a monitor checks each rvalid beat.
module tb_venus_dma_csr;
  import venus_dma_csr_pkg::*;

  localparam logic [31:0] B = 32'h1ffe_0000;

  logic         clk, rst;
  csr_req_t     req;
  csr_resp_t    resp;
  logic         rvalid, start, done_i, irq;
  s_dma_desc_t  desc;
  s_dma_error_t err;

  venus_dma_csr #(.BASE_ADDR(B)) dut (
    .clk(clk), .rst(rst), .csr_req_i(req), .csr_resp_o(resp),
    .csr_rvalid_o(rvalid), .desc_o(desc), .start_o(start),
    .done_i(done_i), .error_i(err), .irq_o(irq)
  );

  typedef struct {
    int unsigned      off;
    logic [31:0]      exp;
    logic [8*12-1:0]  name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;
  logic rd_seen;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or posedge rst)
    if (rst) rd_seen <= 1'b0;
    else     rd_seen <= req.csr_rd_en;

  always @(negedge clk) if (start) start_cnt++;

  always @(negedge clk) begin
    if (rd_seen || rvalid) begin
      checks++;
      if (rvalid !== rd_seen) begin
        errors++;
        $display("FAIL rvalid_timing got %0b exp %0b", rvalid, rd_seen);
      end
    end
    if (rvalid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid got rdata with no pending read");
      end else begin
        exp_t e;
        logic [31:0] got;
        e = sb_q.pop_front();
        got = resp.csr_rdata[8*e.off +: 32];
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %0s got %08h exp %08h", e.name, got, e.exp);
        end
      end
    end
  end

  task automatic chk(input logic [8*12-1:0] nm, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %0s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    req.csr_wr_en = 1'b1;
    req.csr_waddr = a;
    req.csr_wdata = d;
    @(posedge clk); #1;
    req.csr_wr_en = 1'b0;
  endtask

  task automatic rd(input int unsigned off, input logic [31:0] exp, input logic [8*12-1:0] nm);
    exp_t e;
    e.off = off; e.exp = exp; e.name = nm;
    sb_q.push_back(e);
    req.csr_rd_en = 1'b1;
    @(posedge clk); #1;
    req.csr_rd_en = 1'b0;
  endtask

  task automatic pulse_done();
    done_i = 1'b1;
    @(posedge clk); #1;
    done_i = 1'b0;
  endtask

  task automatic pulse_err(input logic [31:0] a, input err_src_t s);
    err.addr = a; err.src = s; err.valid = 1'b1;
    @(posedge clk); #1;
    err = '0;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; req = '0; done_i = 1'b0; err = '0;
    #2;
    chk("rst_resp", resp, '0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_start", start, 0);
    chk("rst_desc", desc, '0);
    chk("rst_irq", irq, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic transfer
    wr(B + 32'h08, 32'h8000_0000);
    wr(B + 32'h10, 32'h9000_0040);
    wr(B + 32'h18, 32'h0000_0100);
    start_cnt = 0;
    wr(B, 32'h3);
    chk("start_pulse", start, 1);
    chk("desc", desc, {32'h8000_0000, 32'h9000_0040, 32'h0000_0100});
    rd(CSR_STAT_OFF, 32'h1, "stat_run");
    rd(CSR_CFG_OFF, 32'h2, "cfg_rd");
    chk("start_once", start_cnt, 1);
    pulse_done();
    rd(CSR_STAT_OFF, 32'h2, "stat_done");
    chk("irq_done", irq, 1);
    wr(B + 32'h20, 32'h2);
    rd(CSR_STAT_OFF, 32'h0, "stat_w1c");
    chk("irq_clr", irq, 0);

    // Back-to-back errors: first one sticks
    wr(B, 32'h3);
    pulse_err(32'h1234_0000, DMA_AXI_RD_ERR);
    pulse_err(32'hdead_0000, DMA_AXI_WR_ERR);
    rd(CSR_STAT_OFF, 32'h4, "stat_err");
    rd(CSR_ERRORADDR_OFF, 32'h1234_0000, "erraddr");
    rd(CSR_ERRORSRC_OFF, 32'h0, "errsrc");
    chk("irq_err", irq, 1);
    wr(B + 32'h20, 32'h4);
    rd(CSR_STAT_OFF, 32'h0, "stat_errclr");
    rd(CSR_ERRORADDR_OFF, 32'h0, "erraddr_clr");
    // Error while idle is still captured
    pulse_err(32'h5555_aaa0, DMA_AXI_WR_ERR);
    rd(CSR_STAT_OFF, 32'h4, "stat_idleerr");
    rd(CSR_ERRORADDR_OFF, 32'h5555_aaa0, "erraddr_idl");
    rd(CSR_ERRORSRC_OFF, 32'h1, "errsrc_idle");
    wr(B + 32'h20, 32'h4);
    rd(CSR_ERRORSRC_OFF, 32'h0, "errsrc_clr");

    // Writes and GO ignored while active
    start_cnt = 0;
    wr(B, 32'h3);
    wr(B + 32'h18, 32'h40);
    wr(B + 32'h08, 32'h1111);
    wr(B, 32'h3);
    rd(CSR_LEN_OFF, 32'h100, "len_locked");
    rd(CSR_SRC_OFF, 32'h8000_0000, "src_locked");
    rd(CSR_STAT_OFF, 32'h1, "stat_active");
    chk("go_ignored", start_cnt, 1);
    pulse_done();
    wr(B + 32'h20, 32'h2);
    wr(B, 32'h3);
    @(posedge clk); #1;
    chk("restart", start_cnt, 2);
    pulse_done();
    wr(B + 32'h20, 32'h2);

    // GO with LEN=0
    wr(B + 32'h18, 32'h0);
    start_cnt = 0;
    wr(B, 32'h1);
    rd(CSR_STAT_OFF, 32'h2, "len0_done");
    repeat (2) @(posedge clk); #1;
    chk("len0_nostart", start_cnt, 0);
    chk("irq_masked", irq, 0);
    wr(B + 32'h20, 32'h2);

    // Decode misses, unmapped offset, read-during-write
    wr(32'h1ffe_0040, 32'haaaa_aaaa);
    wr(32'h2ffe_0008, 32'h5555_5555);
    wr(B + 32'h04, 32'hffff_ffff);
    rd(CSR_SRC_OFF, 32'h8000_0000, "src_decode");
    rd(4, 32'h0, "unmapped");
    rd(CSR_LEN_OFF, 32'h0, "len_decode");
    req.csr_rd_en = 1'b1;
    e.off = CSR_SRC_OFF; e.exp = 32'h8000_0000; e.name = "rw_old";
    sb_q.push_back(e);
    wr(B + 32'h08, 32'h0bad_f00d);
    req.csr_rd_en = 1'b0;
    rd(CSR_SRC_OFF, 32'h0bad_f00d, "rw_new");

    // done_i with DONE W1C in the same cycle: set wins
    wr(B + 32'h18, 32'h100);
    wr(B, 32'h3);
    done_i = 1'b1;
    wr(B + 32'h20, 32'h2);
    done_i = 1'b0;
    rd(CSR_STAT_OFF, 32'h2, "set_wins");
    chk("irq_setwins", irq, 1);
    wr(B + 32'h20, 32'h2);

    // Asynchronous reset mid-transfer
    wr(B, 32'h3);
    chk("pre_rst_st", start, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_start", start, 0);
    chk("arst_desc", desc, '0);
    chk("arst_irq", irq, 0);
    chk("arst_resp", resp, '0);
    @(posedge clk); #1 rst = 1'b0;
    rd(CSR_STAT_OFF, 32'h0, "stat_rst");
    rd(CSR_CFG_OFF, 32'h0, "cfg_rst");
    rd(CSR_SRC_OFF, 32'h0, "src_rst");

    repeat (3) @(posedge clk); #1;
    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
